iob_axistream_in: RTL

AXI4-Stream byte receiver with CPU read-out. Accepts 8-bit beats (with `tlast`) from an upstream AXI-Stream source into an internal 9-bit-wide synchronous FIFO. Software drains the FIFO through the IOb native slave interface. It is the receive-side counterpart of the stream-out block and sits on the same peripheral bus.

---
 rtl/iob_axistream_in.sv | 123 ++++++++++++
 1 files changed

// File: rtl/iob_axistream_in.sv
// AXI4-Stream byte receiver: buffers {tlast,tdata} beats in a synchronous FIFO
// that software drains through the IOb native slave interface.
module iob_axistream_in #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 2,
  parameter int unsigned FIFO_DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [7:0]          tdata,
  input  logic                tvalid,
  output logic                tready,
  input  logic                tlast
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned PtrW  = FIFO_DEPTH_LOG2;
  localparam int unsigned LvlW  = FIFO_DEPTH_LOG2 + 1;

  localparam logic [LvlW-1:0]   LevelFull   = LvlW'(Depth);
  localparam logic [ADDR_W-1:0] AddrOut     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrEmpty   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrLevel   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrSoftRst = ADDR_W'(3);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              tready_q;
  logic              ready_q;
  logic              pop_q;
  logic              out_sel_q;
  logic [DATA_W-1:0] csr_q, csr_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] resp;
  logic [8:0]        ram_q;
  logic [8:0]        mem [Depth];

  logic is_write, is_read, push, pop, flush;
  logic unused_wdata;

  assign unused_wdata = ^wdata[DATA_W-1:1];

  assign is_write = |wstrb;
  assign is_read  = valid & ~is_write;
  assign push     = tvalid & tready_q;
  assign pop      = is_read & (address == AddrOut) & (level_q != '0);
  assign flush    = valid & is_write & (address == AddrSoftRst) & wdata[0];

  // Flush wins over a same-cycle push; the beat is still handshaken but discarded.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      level_d = level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  always_comb begin
    csr_d = '0;
    if (is_read) begin
      if (address == AddrEmpty) csr_d = DATA_W'(level_q == '0);
      if (address == AddrLevel) csr_d = DATA_W'(level_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      tready_q  <= 1'b0;
      ready_q   <= 1'b0;
      pop_q     <= 1'b0;
      out_sel_q <= 1'b0;
      csr_q     <= '0;
      rdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      tready_q  <= (level_d != LevelFull);
      ready_q   <= valid;
      pop_q     <= pop;
      out_sel_q <= is_read & (address == AddrOut);
      csr_q     <= csr_d;
      if (ready_q) rdata_q <= resp;
    end
  end

  // Two-port RAM: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= {tlast, tdata};
  end

  always_ff @(posedge clk) begin
    if (pop) ram_q <= mem[rd_ptr_q];
  end

  // Popped data only exists in the response cycle, so the hold register captures it then.
  always_comb begin
    resp = csr_q;
    if (out_sel_q) resp = pop_q ? DATA_W'({1'b1, ram_q}) : '0;
  end

  assign rdata  = ready_q ? resp : rdata_q;
  assign ready  = ready_q;
  assign tready = tready_q;

endmodule
